// File: rtl/cordic_rotator_seq.sv
// Sequential CORDIC rotation-mode engine.
// One cordic_stage is reused ITERS times. A +/-pi/2 quadrant pre-rotation is applied
// at accept, so the iterative part only ever sees |z| <= pi/2.

// Single CORDIC micro-rotation: d = sign(zi), shift by i, subtract d*phi_i from z.
module cordic_stage (
    input  logic [17:0] xi,
    input  logic [17:0] yi,
    input  logic [17:0] zi,
    input  logic [3:0]  i,
    input  logic [17:0] phi_i,
    output logic [17:0] xip1,
    output logic [17:0] yip1,
    output logic [17:0] zip1
);
    logic [17:0] x_shift;
    logic [17:0] y_shift;
    logic        z_neg;

    assign x_shift = 18'($signed(xi) >>> i);
    assign y_shift = 18'($signed(yi) >>> i);
    assign z_neg   = zi[17];

    // Rotate toward z = 0; all sums wrap modulo 2^18.
    assign xip1 = z_neg ? (xi + y_shift) : (xi - y_shift);
    assign yip1 = z_neg ? (yi - x_shift) : (yi + x_shift);
    assign zip1 = z_neg ? (zi + phi_i)   : (zi - phi_i);
endmodule

module cordic_rotator_seq #(
    parameter int ITERS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] x_in,
    input  logic [17:0] y_in,
    input  logic [17:0] z_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] x_out,
    output logic [17:0] y_out,
    output logic [17:0] z_out
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) in units of pi/2^17, rounded to nearest.
    localparam logic [17:0] ATAN_ROM [0:15] = '{
        18'd32768, 18'd19344, 18'd10221, 18'd5188,
        18'd2604,  18'd1303,  18'd652,   18'd326,
        18'd163,   18'd81,    18'd41,    18'd20,
        18'd10,    18'd5,     18'd3,     18'd1
    };

    localparam logic [3:0] CNT_LAST = 4'(ITERS - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [17:0] x_reg, y_reg, z_reg;
    logic [17:0] x_pre, y_pre, z_pre;
    logic [17:0] x_stage, y_stage, z_stage;
    logic [17:0] phi;
    logic        accept;

    assign phi = ATAN_ROM[cnt_reg];

    cordic_stage u_stage (
        .xi    (x_reg),
        .yi    (y_reg),
        .zi    (z_reg),
        .i     (cnt_reg),
        .phi_i (phi),
        .xip1  (x_stage),
        .yip1  (y_stage),
        .zip1  (z_stage)
    );

    // Quadrant pre-rotation by +/-pi/2 selected from the two angle MSBs.
    always_comb begin
        x_pre = x_in;
        y_pre = y_in;
        z_pre = z_in;
        case (z_in[17:16])
            2'b01: begin
                x_pre = 18'd0 - y_in;
                y_pre = x_in;
                z_pre = z_in - 18'd65536;
            end
            2'b10: begin
                x_pre = y_in;
                y_pre = 18'd0 - x_in;
                z_pre = z_in + 18'd65536;
            end
            default: ;
        endcase
    end

    // Next-state and handshake outputs; in_ready is forced low while reset is held.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Datapath: load pre-rotated operands on accept, iterate through the stage in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= 4'd0;
            x_reg   <= 18'd0;
            y_reg   <= 18'd0;
            z_reg   <= 18'd0;
        end else if (accept) begin
            cnt_reg <= 4'd0;
            x_reg   <= x_pre;
            y_reg   <= y_pre;
            z_reg   <= z_pre;
        end else if (state_reg == RUN) begin
            cnt_reg <= cnt_reg + 4'd1;
            x_reg   <= x_stage;
            y_reg   <= y_stage;
            z_reg   <= z_stage;
        end
    end

    // Results come straight from the working registers, which are frozen in DONE.
    assign x_out = x_reg;
    assign y_out = y_reg;
    assign z_out = z_reg;
endmodule

// File: tb/tb_cordic_rotator_seq.sv
// Directed bench for cordic_rotator_seq (ITERS = 16).
module tb_cordic_rotator_seq;
    localparam int ITERS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] x_in = '0, y_in = '0, z_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] x_out, y_out, z_out;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int accept_cyc = 0;

    cordic_rotator_seq #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int absdiff(input logic [17:0] a, input int b);
        int d;
        d = int'($signed(a)) - b;
        return (d < 0) ? -d : d;
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(input int x, input int y, input int z);
        x_in = 18'(x); y_in = 18'(y); z_in = 18'(z);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        accept_cyc = cyc;
    endtask

    // Counts rising edges from the accept edge until out_valid; -1 on timeout.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges >= 0) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (edges > 40) edges = -1;
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        tests_run++;
        if (x_out !== 18'd0 || y_out !== 18'd0 || z_out !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_data: x=%0d y=%0d z=%0d required 0 0 0", x_out, y_out, z_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    // One rotation with hand-computed expectations (tolerance 16 LSB on x/y).
    task automatic test_rotate(input string name, input int x, input int y, input int z,
                               input int ex, input int ey, input int ztol);
        int edges;
        start_op(x, y, z);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy: in_ready=%b required 0", name, in_ready);
        end
        wait_valid(edges);
        tests_run++;
        if (edges !== ITERS) begin
            tests_failed++;
            $display("FAIL %s_latency: edges=%0d required %0d", name, edges, ITERS);
        end
        tests_run++;
        if (absdiff(x_out, ex) > 16 || absdiff(y_out, ey) > 16 || absdiff(z_out, 0) > ztol) begin
            tests_failed++;
            $display("FAIL %s_value: x=%0d y=%0d z=%0d required %0d %0d 0 (tol 16,16,%0d)",
                     name, $signed(x_out), $signed(y_out), $signed(z_out), ex, ey, ztol);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_drain: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
        $display("[TB] %s x=%0d y=%0d z=%0d", name, $signed(x_out), $signed(y_out), $signed(z_out));
    endtask

    task automatic test_backpressure();
        int edges;
        logic [17:0] hx, hy, hz;
        logic stable_ok;
        logic seen;
        start_op(39797, 0, 0);
        wait_valid(edges);
        tests_run++;
        if (edges !== ITERS || absdiff(x_out, 65536) > 16 || absdiff(y_out, 0) > 16) begin
            tests_failed++;
            $display("FAIL bp_result: edges=%0d x=%0d y=%0d required %0d 65536 0",
                     edges, $signed(x_out), $signed(y_out), ITERS);
        end
        hx = x_out; hy = y_out; hz = z_out;
        stable_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            x_in = 18'(1000 + k); y_in = 18'(2000 + k); z_in = 18'(3000 + k);
            @(posedge clk);
            @(negedge clk);
            if (x_out !== hx || y_out !== hy || z_out !== hz ||
                out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        tests_run++;
        if (stable_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold: outputs or handshake moved while stalled (stable=%b required 1)", stable_ok);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ignored: spurious out_valid=%b required 0", seen);
        end
        $display("[TB] backpressure hold x=%0d y=%0d", $signed(hx), $signed(hy));
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        start_op(39797, 0, 32768);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (x_out !== 18'd0 || y_out !== 18'd0 || z_out !== 18'd0 ||
            out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_clear: x=%0d y=%0d z=%0d ov=%b ir=%b required 0 0 0 0 0",
                     x_out, y_out, z_out, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_abandon: out_valid seen=%b required 0", seen);
        end
        $display("[TB] reset mid-run checked");
        test_rotate("T6_after_rst", 39797, 0, 0, 65536, 0, 2);
    endtask

    task automatic test_back_to_back();
        int edges;
        int first_accept;
        out_ready = 1'b1;
        start_op(39797, 0, 0);
        first_accept = accept_cyc;
        wait_valid(edges);
        tests_run++;
        if (edges !== ITERS || absdiff(x_out, 65536) > 16 || absdiff(y_out, 0) > 16) begin
            tests_failed++;
            $display("FAIL b2b_first: edges=%0d x=%0d y=%0d required %0d 65536 0",
                     edges, $signed(x_out), $signed(y_out), ITERS);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        start_op(39797, 0, 32768);
        tests_run++;
        if (accept_cyc - first_accept !== ITERS + 2) begin
            tests_failed++;
            $display("FAIL b2b_period: period=%0d required %0d", accept_cyc - first_accept, ITERS + 2);
        end
        wait_valid(edges);
        tests_run++;
        if (edges !== ITERS || absdiff(x_out, 46341) > 16 || absdiff(y_out, 46341) > 16) begin
            tests_failed++;
            $display("FAIL b2b_second: edges=%0d x=%0d y=%0d required %0d 46341 46341",
                     edges, $signed(x_out), $signed(y_out), ITERS);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        $display("[TB] back-to-back period=%0d", accept_cyc - first_accept);
    endtask

    initial begin
        test_reset();
        test_rotate("T1_zero",  39797, 0, 0,       65536,  0,     2);
        test_rotate("T2_pi4",   39797, 0, 32768,   46341,  46341, 4);
        test_rotate("T3_pi2",   39797, 0, 65536,   0,      65536, 4);
        test_rotate("T4_negpi", 39797, 0, -131072, -65536, 0,     4);
        test_rotate("T_negpi4", 39797, 0, -32768,  46341,  -46341, 4);
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
